// File: rtl/audio_serdes_param.sv
// Parametrised WM8731 serial path: oversampled BCLK/LRCK, ADC capture, DAC playback, MCLK divider.
// Optional define LOOPBACK_EN adds a loopback port feeding ADC pairs straight into the DAC holding register.
module audio_serdes_param #(
    parameter int DATA_W    = 24,
    parameter int MODE      = 0,
    parameter int CLK_FREQ  = 50000000,
    parameter int MCLK_FREQ = 12288000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              adclrck,
    input  logic              adcdat,
    input  logic              daclrck,
    output logic              dacdat,
    output logic              aud_xclk,
    output logic [DATA_W-1:0] adc_left,
    output logic [DATA_W-1:0] adc_right,
    output logic              adc_valid,
    input  logic              adc_ready,
    output logic              adc_ovf,
    input  logic [DATA_W-1:0] dac_left,
    input  logic [DATA_W-1:0] dac_right,
    input  logic              dac_valid,
    output logic              dac_ready,
    output logic              dac_unf
`ifdef LOOPBACK_EN
    ,
    input  logic              loopback
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (2 * MCLK_FREQ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OFF     = (MODE == 0) ? 1 : 0;
    localparam int LAST    = OFF + DATA_W - 1;

    // ---------------- MCLK divider ----------------
    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            aud_xclk <= 1'b0;
        end else if (div_cnt == CW'(DIV - 1)) begin
            div_cnt  <= '0;
            aud_xclk <= ~aud_xclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // ---------------- synchronisers ----------------
    logic [1:0] bclk_s, alr_s, dlr_s, adat_s;
    logic       bclk_h;
    logic       rise, fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s <= '0;
            alr_s  <= '0;
            dlr_s  <= '0;
            adat_s <= '0;
            bclk_h <= 1'b0;
        end else begin
            bclk_s <= {bclk_s[0], bclk};
            alr_s  <= {alr_s[0], adclrck};
            dlr_s  <= {dlr_s[0], daclrck};
            adat_s <= {adat_s[0], adcdat};
            bclk_h <= bclk_s[1];
        end
    end

    assign rise = bclk_s[1] & ~bclk_h;
    assign fall = ~bclk_s[1] & bclk_h;

    // ---------------- ADC capture ----------------
    // Channel index 0 = left, 1 = right. The first edge after reset only primes the LRCK history.
    logic                   adc_primed, alr_prev, adc_ch, left_done, pair_pend;
    logic [5:0]             adc_j, a_j_now;
    logic [1:0][DATA_W-1:0] adc_sh;
    logic                   a_edge, a_ch_new, a_ch_now, a_cap;

    assign a_edge   = alr_s[1] != alr_prev;
    assign a_ch_new = (MODE == 0) ? alr_s[1] : ~alr_s[1];
    assign a_j_now  = a_edge ? 6'd0 : ((adc_j == 6'd63) ? 6'd63 : adc_j + 6'd1);
    assign a_ch_now = a_edge ? a_ch_new : adc_ch;
    assign a_cap    = (a_j_now <= 6'(LAST)) && !(OFF == 1 && a_j_now == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_primed <= 1'b0;
            alr_prev   <= 1'b0;
            adc_ch     <= 1'b0;
            left_done  <= 1'b0;
            pair_pend  <= 1'b0;
            adc_j      <= 6'd63;
            adc_sh     <= '0;
        end else begin
            pair_pend <= 1'b0;
            if (rise) begin
                adc_primed <= 1'b1;
                alr_prev   <= alr_s[1];
                if (adc_primed) begin
                    adc_j  <= a_j_now;
                    adc_ch <= a_ch_now;
                    if (a_edge && !a_ch_new)
                        left_done <= 1'b0;
                    if (a_cap) begin
                        adc_sh[a_ch_now] <= {adc_sh[a_ch_now][DATA_W-2:0], adat_s[1]};
                        // A short half-frame never reaches LAST, so it never completes a pair.
                        if (a_j_now == 6'(LAST)) begin
                            if (!a_ch_now)
                                left_done <= 1'b1;
                            else if (left_done) begin
                                pair_pend <= 1'b1;
                                left_done <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_left  <= '0;
            adc_right <= '0;
            adc_valid <= 1'b0;
            adc_ovf   <= 1'b0;
        end else begin
            adc_ovf <= 1'b0;
            if (pair_pend) begin
                adc_left  <= adc_sh[0];
                adc_right <= adc_sh[1];
                adc_valid <= 1'b1;
                adc_ovf   <= adc_valid & ~adc_ready;
            end else if (adc_ready) begin
                adc_valid <= 1'b0;
            end
        end
    end

    // ---------------- DAC playback ----------------
    logic                   dac_primed, dlr_prev, dac_ch, hold_full;
    logic [5:0]             dac_k, d_k_now, d_idx;
    logic [1:0][DATA_W-1:0] hold, dsh;
    logic [DATA_W-1:0]      dword;
    logic                   d_edge, d_ch_new, d_ch_now, frame_start, d_in, dbit;

    assign d_edge      = dlr_s[1] != dlr_prev;
    assign d_ch_new    = (MODE == 0) ? dlr_s[1] : ~dlr_s[1];
    assign d_k_now     = d_edge ? 6'd0 : ((dac_k == 6'd63) ? 6'd63 : dac_k + 6'd1);
    assign d_ch_now    = d_edge ? d_ch_new : dac_ch;
    assign frame_start = fall & dac_primed & d_edge & ~d_ch_new;
    assign d_idx       = 6'(LAST) - d_k_now;
    assign d_in        = (d_k_now <= 6'(LAST)) && !(OFF == 1 && d_k_now == 6'd0);

    // At a frame start the left word is not yet in dsh, so take it from where it is about to come from.
    always_comb begin
        dword = dsh[d_ch_now];
        if (frame_start)
            dword = hold_full ? hold[0] : dsh[0];
        dbit = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (d_in && d_idx == 6'(i))
                dbit = dword[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_primed <= 1'b0;
            dlr_prev   <= 1'b0;
            dac_ch     <= 1'b0;
            dac_k      <= 6'd63;
            dacdat     <= 1'b0;
            dac_unf    <= 1'b0;
            hold_full  <= 1'b0;
            hold       <= '0;
            dsh        <= '0;
        end else begin
            dac_unf <= 1'b0;
            if (fall) begin
                dac_primed <= 1'b1;
                dlr_prev   <= dlr_s[1];
                if (dac_primed) begin
                    dac_k  <= d_k_now;
                    dac_ch <= d_ch_now;
                    dacdat <= dbit;
                    if (frame_start) begin
                        if (hold_full) begin
                            dsh       <= hold;
                            hold_full <= 1'b0;
                        end else begin
                            dac_unf <= 1'b1;
                        end
                    end
                end
            end
            // Loads come after the frame-start update so a coincident load wins the holding register.
`ifdef LOOPBACK_EN
            if (loopback) begin
                if (pair_pend) begin
                    hold      <= adc_sh;
                    hold_full <= 1'b1;
                end
            end else
`endif
            if (dac_valid && dac_ready) begin
                hold      <= {dac_right, dac_left};
                hold_full <= 1'b1;
            end
        end
    end

`ifdef LOOPBACK_EN
    assign dac_ready = ~hold_full & ~loopback;
`else
    assign dac_ready = ~hold_full;
`endif

endmodule

// File: tb/tb_audio_serdes_param.sv
// Directed bench: I2S/24-bit instance for ADC capture and backpressure, LJ/16-bit instance for DAC playback.
module tb_audio_serdes_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bclk = 1'b0, alr = 1'b0, adat = 1'b0, dlr = 1'b0;
    logic adc_ready = 1'b1;
    logic zero1 = 1'b0, one1 = 1'b1;
    logic [23:0] zero24 = '0;

    logic        i_dacdat, i_xclk, i_adc_valid, i_adc_ovf, i_dac_ready, i_dac_unf;
    logic [23:0] i_adc_left, i_adc_right;

    logic        l_dacdat, l_xclk, l_adc_valid, l_adc_ovf, l_dac_ready, l_dac_unf;
    logic [15:0] l_adc_left, l_adc_right, dac_l = '0, dac_r = '0;
    logic        dac_v = 1'b0;

    int errors = 0, checks = 0;
    int ovf_cnt = 0, unf_cnt = 0, hs_cnt = 0;
    logic [47:0] adc_q[$];
    logic [31:0] dac_q[$];

    always #10 clk = ~clk;

    audio_serdes_param #(.DATA_W(24), .MODE(0)) dut_i2s (
        .clk(clk), .reset(reset), .bclk(bclk), .adclrck(alr), .adcdat(adat), .daclrck(zero1),
        .dacdat(i_dacdat), .aud_xclk(i_xclk), .adc_left(i_adc_left), .adc_right(i_adc_right),
        .adc_valid(i_adc_valid), .adc_ready(adc_ready), .adc_ovf(i_adc_ovf),
        .dac_left(zero24), .dac_right(zero24), .dac_valid(zero1), .dac_ready(i_dac_ready),
        .dac_unf(i_dac_unf)
`ifdef LOOPBACK_EN
        , .loopback(zero1)
`endif
    );

    audio_serdes_param #(.DATA_W(16), .MODE(1)) dut_lj (
        .clk(clk), .reset(reset), .bclk(bclk), .adclrck(zero1), .adcdat(zero1), .daclrck(dlr),
        .dacdat(l_dacdat), .aud_xclk(l_xclk), .adc_left(l_adc_left), .adc_right(l_adc_right),
        .adc_valid(l_adc_valid), .adc_ready(one1), .adc_ovf(l_adc_ovf),
        .dac_left(dac_l), .dac_right(dac_r), .dac_valid(dac_v), .dac_ready(l_dac_ready),
        .dac_unf(l_dac_unf)
`ifdef LOOPBACK_EN
        , .loopback(zero1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ADC handshake pops the oldest expected pair.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (i_adc_ovf) ovf_cnt++;
            if (l_dac_unf) unf_cnt++;
            if (i_adc_valid && adc_ready) begin
                logic [47:0] e;
                hs_cnt++;
                chk("adc_pair_expected", adc_q.size() > 0, 1'b1);
                if (adc_q.size() > 0) begin
                    e = adc_q.pop_front();
                    chk("adc_left", i_adc_left, e[47:24]);
                    chk("adc_right", i_adc_right, e[23:0]);
                end
            end
        end
    end

    // One BCLK period: codec changes LRCK/data on the falling edge; dacdat is sampled just before the rise.
    task automatic slot(input logic a_lr, input logic a_d, input logic d_lr, output logic dout);
        @(negedge clk);
        bclk = 1'b0; alr = a_lr; adat = a_d; dlr = d_lr;
        repeat (7) @(negedge clk);
        dout = l_dacdat;
        @(negedge clk);
        bclk = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r, input int llen, input bit chk_dac);
        logic [15:0] gl = '0, gr = '0;
        logic [31:0] e;
        logic d;
        int bad = 0;
        for (int t = 0; t < llen; t++) begin
            slot(1'b0, (t >= 1 && t <= 24) ? l[24-t] : 1'b0, 1'b1, d);
            if (t < 16) gl[15-t] = d;
            else if (d) bad++;
        end
        for (int t = 0; t < 32; t++) begin
            slot(1'b1, (t >= 1 && t <= 24) ? r[24-t] : 1'b0, 1'b0, d);
            if (t < 16) gr[15-t] = d;
            else if (d) bad++;
        end
        if (chk_dac) begin
            chk("dac_pair_expected", dac_q.size() > 0, 1'b1);
            if (dac_q.size() > 0) begin
                e = dac_q.pop_front();
                chk("dacdat_left", gl, e[31:16]);
                chk("dacdat_right", gr, e[15:0]);
                chk("dacdat_pad_zero", bad, 0);
            end
        end
    endtask

    task automatic dac_load(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        @(negedge clk);
        dac_l = l; dac_r = r; dac_v = 1'b1;
        while (!l_dac_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dac_ready_wait", n < 200, 1'b1);
        @(negedge clk);
        dac_v = 1'b0;
        dac_q.push_back({l, r});
    endtask

    task automatic idle(input int n);
        logic d;
        for (int i = 0; i < n; i++) slot(1'b1, 1'b0, 1'b0, d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] xs_i, xs_l;
        bit ok;
        int base;

        repeat (3) @(negedge clk);
        chk("rst_dacdat", i_dacdat, 1'b0);
        chk("rst_adc_valid", i_adc_valid, 1'b0);
        chk("rst_adc_left", i_adc_left, 24'h0);
        chk("rst_adc_ovf", i_adc_ovf, 1'b0);
        chk("rst_dac_ready", i_dac_ready, 1'b1);
        chk("rst_dac_unf", l_dac_unf, 1'b0);
        chk("rst_xclk", i_xclk, 1'b0);
        chk("rst_lj_dac_ready", l_dac_ready, 1'b1);
        chk("rst_lj_dacdat", l_dacdat, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            xs_i[i] = i_xclk;
            xs_l[i] = l_xclk;
        end
        ok = (xs_i != 16'h0);
        for (int i = 0; i < 14; i++)
            if (xs_i[i] === xs_i[i+2] || xs_l[i] === xs_l[i+2]) ok = 1'b0;
        chk("xclk_period4", ok, 1'b1);

        // LJ playback of 8001/7FFE; I2S capture of A5A5A5/3C3C3C in the same frame.
        dac_load(16'h8001, 16'h7FFE);
        chk("dac_ready_full", l_dac_ready, 1'b0);
        idle(4);
        adc_q.push_back({24'hA5A5A5, 24'h3C3C3C});
        frame(24'hA5A5A5, 24'h3C3C3C, 32, 1);
        chk("adc_q_drained1", adc_q.size(), 0);
        chk("adc_handshakes1", hs_cnt, 1);
        chk("dac_ready_after_start", l_dac_ready, 1'b1);

        dac_load(16'h1234, 16'hABCD);
        adc_q.push_back({24'h123456, 24'hFEDCBA});
        frame(24'h123456, 24'hFEDCBA, 32, 1);
        chk("unf_none", unf_cnt, 0);

        // Underflow: no new pair, previous pair replays.
        dac_q.push_back({16'h1234, 16'hABCD});
        adc_q.push_back({24'h0F0F0F, 24'hF0F0F0});
        frame(24'h0F0F0F, 24'hF0F0F0, 32, 1);
        chk("unf_once", unf_cnt, 1);

        // Backpressure over two frames: the first pair is overwritten by the second.
        @(negedge clk);
        adc_ready = 1'b0;
        base = ovf_cnt;
        adc_q.push_back({24'h111111, 24'h222222});
        frame(24'h111111, 24'h222222, 32, 0);
        adc_q.push_back({24'hABCDEF, 24'h987654});
        frame(24'hABCDEF, 24'h987654, 32, 0);
        void'(adc_q.pop_front());
        chk("ovf_pulses", ovf_cnt - base, 1);
        chk("bp_valid_held", i_adc_valid, 1'b1);
        chk("bp_hold_left", i_adc_left, 24'hABCDEF);
        chk("bp_hold_right", i_adc_right, 24'h987654);
        @(negedge clk);
        adc_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_drained", adc_q.size(), 0);
        chk("bp_valid_clear", i_adc_valid, 1'b0);

        // Short left half-frame: no pair, then a full frame recovers.
        base = hs_cnt;
        frame(24'h777777, 24'h555555, 12, 0);
        chk("short_no_pair", hs_cnt - base, 0);
        chk("short_valid_low", i_adc_valid, 1'b0);
        adc_q.push_back({24'h5A5A5A, 24'hC3C3C3});
        frame(24'h5A5A5A, 24'hC3C3C3, 32, 0);
        chk("recover_pair", hs_cnt - base, 1);
        chk("adc_q_final", adc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
